// File: rtl/ifetch_unit.sv
// ifetch_unit: PC-driven fetch FSM with a small decode-side FIFO.
// Optional misaligned-fetch trap under `IFETCH_MISALIGN_CHECK_EN.
module ifetch_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] pc_i,
  output logic        pc_we_o,
  output logic [63:0] pc_next_o,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  output logic        instr_fault_o,
  input  logic        instr_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e        state_q;
  logic [63:0]   req_pc_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   pc_mem [FIFO_DEPTH];
  logic [31:0]   ins_mem [FIFO_DEPTH];

  logic        not_full;
  logic        misalign;
  logic        in_req;
  logic        req;
  logic        grant;
  logic        fault_push;
  logic        rsp_push;
  logic        push;
  logic        pop;
  logic [63:0] push_pc;
  logic [31:0] push_ins;

  assign not_full = cnt_q < CW'(FIFO_DEPTH);

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misalign = pc_i[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif

  assign in_req = (state_q == S_REQ)
                & not_full
                & ~redirect_i;
  assign req        = in_req & ~misalign;
  assign fault_push = in_req & misalign;
  assign grant      = req & imem_gnt_i;
  assign rsp_push   = (state_q == S_WAIT)
                    & imem_rvalid_i
                    & ~redirect_i;
  assign push = rsp_push | fault_push;
  assign pop  = instr_valid_o & instr_ready_i;

  assign push_pc  = fault_push ? pc_i : req_pc_q;
  assign push_ins = fault_push ? 32'h0
                               : imem_rdata_i;

  // Every output is forced low while reset is held
  assign imem_req_o  = rst_ni & req;
  assign imem_addr_o = rst_ni ? pc_i : 64'h0;
  assign pc_we_o     = rst_ni
                     & (redirect_i | grant | fault_push);

  always_comb begin
    pc_next_o = 64'h0;
    if (rst_ni) begin
      unique case (1'b1)
        redirect_i: pc_next_o = redirect_pc_i;
        fault_push: pc_next_o = pc_i;
        default:    pc_next_o = pc_i + 64'd4;
      endcase
    end
  end

  assign instr_valid_o = rst_ni
                       & (cnt_q != '0)
                       & ~redirect_i;
  assign instr_o    = rst_ni ? ins_mem[rd_q] : 32'h0;
  assign instr_pc_o = rst_ni ? pc_mem[rd_q] : 64'h0;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic flt_mem [FIFO_DEPTH];

  // Fault flag storage travels with each entry
  always_ff @(posedge clk_i) begin
    if (push) flt_mem[wr_q] <= fault_push;
  end

  assign instr_fault_o = rst_ni & flt_mem[rd_q];
`else
  assign instr_fault_o = 1'b0;
`endif

  // Fetch FSM: one request in flight, drop it after a redirect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_REQ;
      req_pc_q <= 64'h0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (grant) begin
            state_q  <= S_WAIT;
            req_pc_q <= pc_i;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i)   state_q <= S_REQ;
          else if (redirect_i) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (imem_rvalid_i) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // FIFO pointers and occupancy; redirect empties it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (redirect_i) begin
      rd_q  <= wr_q;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry payload storage, written on push
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_q]  <= push_pc;
      ins_mem[wr_q] <= push_ins;
    end
  end

endmodule
